ps2_tx: RTL and testbench

Host-to-device PS/2 transmitter; the sending counterpart of the keyboard receiver. Sends one command byte (e.g. LED set 0xED, reset 0xFF) to the keyboard over the shared open-drain ps2c/ps2d lines. It drives the lines only through active-high pull-low enables; tristate buffers live in top. While busy, tx_idle=0 so top can deassert the receiver's rx_en.

---
 rtl/ps2_tx.sv | 257 +++++++++++++++++++++++++
 tb/tb_ps2_tx.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_tx.sv
// ---------------------------------------------------------------------------
// ps2_tx : host-to-device PS/2 transmitter
//
// Sends one command byte to a PS/2 device over the shared open-drain clock
// and data lines. The block never drives a line high. It only asserts
// active-high pull-low enables. The tristate buffers live in the top level.
// While a frame is in flight tx_idle is low, so the top level can gate off
// the keyboard receiver.
//
// Frame sequence:
//   request-to-send (clock held low) -> start bit -> d0..d7 -> odd parity
//   -> stop (line released) -> device ACK -> wait for bus release.
//
// Parameters:
//   INHIBIT_CYCLES : clk cycles that ps2c is held low for request-to-send
//   FILTER_LEN     : length of the ps2c glitch-filter shift register
//   TIMEOUT_CYCLES : watchdog limit per device-clocked wait state
//
// Ports:
//   clk          in   system clock
//   reset        in   synchronous, active-high reset
//   wr_ps2       in   one-cycle start strobe, honoured only while tx_idle=1
//   din[7:0]     in   byte to send, latched on the accepted wr_ps2
//   ps2c_in      in   PS/2 clock line level from the pad
//   ps2d_in      in   PS/2 data line level from the pad
//   ps2c_oe      out  1 = pull ps2c low
//   ps2d_oe      out  1 = pull ps2d low
//   tx_idle      out  1 = ready, both lines released
//   tx_done_tick out  one-cycle pulse when a frame completes
//   ack_err      out  status of the last frame, 1 = no ACK (or timed out)
//
// Build option:
//   PS2_TX_TIMEOUT_EN : when defined, a watchdog aborts a frame whose device
//                       stops clocking. It then releases both lines, sets
//                       ack_err and returns to idle. When undefined, the
//                       block waits indefinitely for device clocks.
// ---------------------------------------------------------------------------
module ps2_tx #(
  parameter int INHIBIT_CYCLES = 13000,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_ps2,
  input  logic [7:0] din,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  output logic       tx_idle,
  output logic       tx_done_tick,
  output logic       ack_err
);

  localparam int CNT_W = $clog2(INHIBIT_CYCLES + 1);

  // Elaboration-time sanity checks on the configuration.
  if (INHIBIT_CYCLES < 1) begin : g_bad_inhibit
    $error("ps2_tx: INHIBIT_CYCLES must be at least 1");
  end
  if (FILTER_LEN < 2) begin : g_bad_filter
    $error("ps2_tx: FILTER_LEN must be at least 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("ps2_tx: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    RTS,
    START,
    DATA,
    STOP,
    ACK,
    WAITREL
  } state_t;

  state_t                state, state_next;
  logic [FILTER_LEN-1:0] filt_reg, filt_next;
  logic                  f_val, f_val_next;
  logic                  fall_edge;
  logic [8:0]            shreg, shreg_next;
  logic [CNT_W-1:0]      cnt, cnt_next;
  logic [3:0]            nbit, nbit_next;
  logic                  done, done_next;
  logic                  err, err_next;
  logic                  wd_expired;

  // ------------------------------------------------------------------------
  // ps2c glitch filter. The filtered level only changes once the whole
  // window agrees, so pulses shorter than FILTER_LEN cycles are ignored.
  // While the host itself holds the clock low during request-to-send, the
  // filter also sees that. The resulting falling edge is harmless because
  // RTS ignores fall_edge.
  // ------------------------------------------------------------------------
  assign filt_next = {ps2c_in, filt_reg[FILTER_LEN-1:1]};

  always_comb begin
    f_val_next = f_val;
    if (&filt_next) begin
      f_val_next = 1'b1;
    end else if (~|filt_next) begin
      f_val_next = 1'b0;
    end
  end

  assign fall_edge = f_val & ~f_val_next;

  // ------------------------------------------------------------------------
  // Optional watchdog. It restarts on every state change and on every
  // device clock edge. It only fires in the states that depend on the
  // device to make progress.
  // ------------------------------------------------------------------------
`ifdef PS2_TX_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            waiting;

  assign waiting    = state inside {START, DATA, STOP, ACK, WAITREL};
  assign wd_expired = waiting && !fall_edge &&
                      (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset || (state_next != state) || fall_edge || !waiting) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + WD_W'(1);
    end
  end
`else
  assign wd_expired = 1'b0;
`endif

  // ------------------------------------------------------------------------
  // Control registers (reset)
  // ------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      filt_reg <= '1;
      f_val    <= 1'b1;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_next;
      filt_reg <= filt_next;
      f_val    <= f_val_next;
      done     <= done_next;
      err      <= err_next;
    end
  end

  // ------------------------------------------------------------------------
  // Frame data and counters (always loaded before use, no reset needed)
  // ------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    shreg <= shreg_next;
    cnt   <= cnt_next;
    nbit  <= nbit_next;
  end

  // ------------------------------------------------------------------------
  // Next-state and line-drive logic. The host changes data on the device's
  // falling clock edge, and the device samples on the rising edge. Each
  // filtered falling edge advances the frame by exactly one step.
  // ------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    shreg_next = shreg;
    cnt_next   = cnt;
    nbit_next  = nbit;
    err_next   = err;
    done_next  = 1'b0;
    ps2c_oe    = 1'b0;
    ps2d_oe    = 1'b0;
    tx_idle    = 1'b0;

    unique case (state)
      IDLE: begin
        tx_idle = 1'b1;
        if (wr_ps2) begin
          shreg_next = {~^din, din};
          cnt_next   = CNT_W'(INHIBIT_CYCLES - 1);
          err_next   = 1'b0;
          state_next = RTS;
        end
      end

      RTS: begin
        ps2c_oe = 1'b1;
        if (cnt == '0) begin
          state_next = START;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end

      START: begin
        // Clock released, data held low as the start bit. The device
        // responds by generating clocks.
        ps2d_oe = 1'b1;
        if (fall_edge) begin
          nbit_next  = 4'd0;
          state_next = DATA;
        end
      end

      DATA: begin
        // shreg[0] walks through d0..d7 and then parity.
        ps2d_oe = ~shreg[0];
        if (fall_edge) begin
          shreg_next = {1'b0, shreg[8:1]};
          nbit_next  = nbit + 4'd1;
          if (nbit == 4'd8) begin
            state_next = STOP;
          end
        end
      end

      STOP: begin
        if (fall_edge) begin
          state_next = ACK;
        end
      end

      ACK: begin
        if (fall_edge) begin
          err_next   = ps2d_in;
          state_next = WAITREL;
        end
      end

      WAITREL: begin
        if (f_val && ps2d_in) begin
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    if (wd_expired) begin
      err_next   = 1'b1;
      done_next  = 1'b1;
      state_next = IDLE;
    end
  end

  assign tx_done_tick = done;
  assign ack_err      = err;

endmodule

// File: tb/tb_ps2_tx.sv
// ---------------------------------------------------------------------------
// tb_ps2_tx : directed testbench for ps2_tx.
// A behavioural PS/2 device drives the clock and samples data on each
// rising edge. It can ACK or withhold the ACK, inject clock glitches, and
// pulse wr_ps2 in the middle of a frame. Expected frame contents, including
// the parity bits, are written by hand in the calls.
// ---------------------------------------------------------------------------
module tb_ps2_tx;

  localparam int INH  = 20;
  localparam int FL   = 8;
  localparam int TO   = 300;
  localparam int HALF = 40;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_ps2 = 1'b0;
  logic [7:0] din = 8'h00;
  logic       ps2c_in, ps2d_in;
  logic       ps2c_oe, ps2d_oe, tx_idle, tx_done_tick, ack_err;

  logic dev_c = 1'b1;
  logic dev_d_low = 1'b0;

  int n_tests = 0;
  int n_fail = 0;
  int tick_cnt = 0;
  int both_cnt = 0;
  logic idle_at_tick = 1'b0;

  always #5 clk = ~clk;

  // Open-drain bus: a line is low when either side pulls it.
  assign ps2c_in = ps2c_oe ? 1'b0 : dev_c;
  assign ps2d_in = (ps2d_oe || dev_d_low) ? 1'b0 : 1'b1;

  ps2_tx #(
    .INHIBIT_CYCLES(INH),
    .FILTER_LEN    (FL),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_ps2      (wr_ps2),
    .din         (din),
    .ps2c_in     (ps2c_in),
    .ps2d_in     (ps2d_in),
    .ps2c_oe     (ps2c_oe),
    .ps2d_oe     (ps2d_oe),
    .tx_idle     (tx_idle),
    .tx_done_tick(tx_done_tick),
    .ack_err     (ack_err)
  );

  always @(negedge clk) begin
    if (tx_done_tick === 1'b1) begin
      tick_cnt     <= tick_cnt + 1;
      idle_at_tick <= tx_idle;
    end
    if (ps2c_oe === 1'b1 && ps2d_oe === 1'b1) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // One device clock half-period. Optionally injects a 3-cycle glitch of
  // the opposite level, and optionally pulses wr_ps2 at cycle wr_at.
  task automatic phase(input logic level, input bit glitch, input int wr_at);
    for (int i = 0; i < HALF; i++) begin
      dev_c  = (glitch && i >= 12 && i < 15) ? ~level : level;
      wr_ps2 = (i == wr_at);
      if (i == wr_at) din = 8'h00;
      @(negedge clk);
    end
    wr_ps2 = 1'b0;
    dev_c  = level;
  endtask

  // Device side of a frame. It generates npulse clock pulses. Rising edges
  // 0..9 sample d0..d7, parity and stop. With ack set, the device pulls
  // data low across pulses 10 and 11.
  task automatic dev_frame(input bit ack, input bit glitch, input int wr_at,
                           input int npulse, output logic [9:0] rx);
    bit g;
    rx = '0;
    repeat (20) @(negedge clk);
    for (int p = 0; p < npulse; p++) begin
      g = glitch && p >= 1 && p <= 8;
      if (p == 10 && ack) dev_d_low = 1'b1;
      phase(1'b0, g, (p == 3) ? wr_at : -1);
      if (p < 10) rx[p] = ps2d_in;
      if (p == 11) dev_d_low = 1'b0;
      phase(1'b1, g, -1);
    end
  endtask

  task automatic start_tx(input logic [7:0] b, output int rts_len);
    wr_ps2 = 1'b1;
    din    = b;
    @(negedge clk);
    wr_ps2  = 1'b0;
    din     = ~b;
    rts_len = 0;
    while (ps2c_oe === 1'b1 && rts_len < 1000) begin
      rts_len++;
      @(negedge clk);
    end
  endtask

  task automatic run_frame(input string tag, input logic [7:0] b, input logic par,
                           input bit ack, input bit glitch, input int wr_at,
                           input logic exp_err);
    int rts_len;
    int t0;
    int busy;
    logic [9:0] rx;
    t0 = tick_cnt;
    start_tx(b, rts_len);
    check({tag, "_rts_len"}, rts_len, INH);
    check({tag, "_start_bit"}, {31'd0, ps2d_oe}, 1);
    dev_frame(ack, glitch, wr_at, 12, rx);
    repeat (30) @(negedge clk);
    check({tag, "_frame"}, {22'd0, rx}, {22'd0, 1'b1, par, b});
    check({tag, "_done_ticks"}, tick_cnt - t0, 1);
    check({tag, "_idle_at_done"}, {31'd0, idle_at_tick}, 1);
    check({tag, "_ack_err"}, {31'd0, ack_err}, {31'd0, exp_err});
    busy = 0;
    for (int i = 0; i < 20; i++) begin
      if (ps2c_oe !== 1'b0 || tx_idle !== 1'b1) busy++;
      @(negedge clk);
    end
    check({tag, "_stays_idle"}, busy, 0);
  endtask

  initial begin
    int rts_len;
    int got;
    logic [9:0] rx;

    // Reset state
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_ps2c_oe", {31'd0, ps2c_oe}, 0);
    check("rst_ps2d_oe", {31'd0, ps2d_oe}, 0);
    check("rst_tx_idle", {31'd0, tx_idle}, 1);
    check("rst_done", {31'd0, tx_done_tick}, 0);
    check("rst_ack_err", {31'd0, ack_err}, 0);
    repeat (5) @(negedge clk);

    // Normal frames with ACK. Parity is written by hand (odd parity).
    run_frame("ed", 8'hED, 1'b1, 1'b1, 1'b0, -1, 1'b0);
    run_frame("x00", 8'h00, 1'b1, 1'b1, 1'b0, -1, 1'b0);
    run_frame("xff", 8'hFF, 1'b1, 1'b1, 1'b0, -1, 1'b0);
    run_frame("x01", 8'h01, 1'b0, 1'b1, 1'b0, -1, 1'b0);
    // Device withholds the ACK
    run_frame("noack", 8'hA5, 1'b1, 1'b0, 1'b0, -1, 1'b1);
    // Clock glitches during the data bits
    run_frame("glitch", 8'h3C, 1'b1, 1'b1, 1'b1, -1, 1'b0);
    // wr_ps2 pulsed mid-frame must be ignored
    run_frame("midwr", 8'h96, 1'b1, 1'b1, 1'b0, 20, 1'b0);

    // Reset while bit 4 is on the line
    start_tx(8'h5A, rts_len);
    dev_frame(1'b0, 1'b0, -1, 5, rx);
    check("pre_rst_busy", {31'd0, tx_idle}, 0);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_ps2c_oe", {31'd0, ps2c_oe}, 0);
    check("midrst_ps2d_oe", {31'd0, ps2d_oe}, 0);
    check("midrst_tx_idle", {31'd0, tx_idle}, 1);
    reset = 1'b0;
    dev_c = 1'b1;
    dev_d_low = 1'b0;
    repeat (20) @(negedge clk);
    run_frame("after_rst", 8'hFF, 1'b1, 1'b1, 1'b0, -1, 1'b0);

    // Device stays silent after request-to-send
    start_tx(8'h12, rts_len);
    check("silent_rts_len", rts_len, INH);
`ifdef PS2_TX_TIMEOUT_EN
    got = 0;
    for (int i = 0; i < TO + 100 && got == 0; i++) begin
      @(negedge clk);
      if (tx_done_tick === 1'b1) got = 1;
    end
    check("to_done", got, 1);
    check("to_ps2c_oe", {31'd0, ps2c_oe}, 0);
    check("to_ps2d_oe", {31'd0, ps2d_oe}, 0);
    check("to_tx_idle", {31'd0, tx_idle}, 1);
    check("to_ack_err", {31'd0, ack_err}, 1);
`else
    got = tick_cnt;
    repeat (TO + 100) @(negedge clk);
    check("hold_no_done", tick_cnt - got, 0);
    check("hold_ps2d_oe", {31'd0, ps2d_oe}, 1);
    check("hold_ps2c_oe", {31'd0, ps2c_oe}, 0);
    check("hold_tx_idle", {31'd0, tx_idle}, 0);
`endif
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check("never_both_oe", both_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
